// File: rtl/led_sequencer_if.sv
// rtl/led_sequencer_if.sv - control inputs and display outputs of the LED sequencer
interface led_sequencer_if;
  logic       tick;
  logic       start;
  logic       fake_sel;
  logic       round_done;
  logic       speed_req;
  logic [2:0] led_control;
  logic       in_play;
  logic       round_over;

  modport master (
    output tick, start, fake_sel, round_done, speed_req,
    input  led_control, in_play, round_over
  );

  modport slave (
    input  tick, start, fake_sel, round_done, speed_req,
    output led_control, in_play, round_over
  );
endinterface

// File: rtl/led_sequencer.sv
// rtl/led_sequencer.sv - six-state round sequencer driving the LED multiplexer select code
module led_sequencer #(
  parameter int RESET_TICKS = 2000,
  parameter int WAIT_TICKS  = 1000,
  parameter int FAKE_TICKS  = 500,
  parameter int SPEED_TICKS = 1500
) (
  input logic           clk,
  input logic           rst,
  led_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    DARK       = 3'b000,
    SHOW_RESET = 3'b001,
    WAIT       = 3'b010,
    PLAY       = 3'b011,
    FAKE       = 3'b100,
    SPEED      = 3'b110
  } state_t;

  localparam logic [11:0] RESET_LAST = 12'(RESET_TICKS - 1);
  localparam logic [11:0] WAIT_LAST  = 12'(WAIT_TICKS - 1);
  localparam logic [11:0] FAKE_LAST  = 12'(FAKE_TICKS - 1);
  localparam logic [11:0] SPEED_LAST = 12'(SPEED_TICKS - 1);

  // Plain vector so the unused codes 101/111 remain representable and recoverable.
  logic [2:0]  state;
  logic [11:0] count;
  logic        in_play;
  logic        round_over;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= SHOW_RESET;
      count      <= '0;
      in_play    <= 1'b0;
      round_over <= 1'b0;
    end else begin
      round_over <= 1'b0;
      case (state)
        SHOW_RESET: begin
          if (bus.tick) begin
            if (count == RESET_LAST) begin
              state <= DARK;
              count <= '0;
            end else begin
              count <= count + 12'd1;
            end
          end
        end
        DARK: begin
          if (bus.start) begin
            state <= WAIT;
            count <= '0;
          end else if (bus.speed_req) begin
            state <= SPEED;
            count <= '0;
          end
        end
        WAIT: begin
          if (bus.tick) begin
            if (count == WAIT_LAST) begin
              count <= '0;
              if (bus.fake_sel) begin
                state <= FAKE;
              end else begin
                state   <= PLAY;
                in_play <= 1'b1;
              end
            end else begin
              count <= count + 12'd1;
            end
          end
        end
        PLAY: begin
          if (bus.round_done) begin
            state      <= DARK;
            count      <= '0;
            in_play    <= 1'b0;
            round_over <= 1'b1;
          end
        end
        FAKE: begin
          if (bus.tick) begin
            if (count == FAKE_LAST) begin
              state      <= DARK;
              count      <= '0;
              round_over <= 1'b1;
            end else begin
              count <= count + 12'd1;
            end
          end
        end
        SPEED: begin
          if (bus.tick) begin
            if (count == SPEED_LAST) begin
              state <= DARK;
              count <= '0;
            end else begin
              count <= count + 12'd1;
            end
          end
        end
        default: begin
          state   <= DARK;
          count   <= '0;
          in_play <= 1'b0;
        end
      endcase
    end
  end

  assign bus.led_control = state;
  assign bus.in_play     = in_play;
  assign bus.round_over  = round_over;

endmodule

// File: tb/tb_led_sequencer.sv
// tb/tb_led_sequencer.sv - scoreboard bench for led_sequencer display sequences
module tb_led_sequencer;

  logic clk;
  logic rst;
  led_sequencer_if bus();

  led_sequencer #(
    .RESET_TICKS(3),
    .WAIT_TICKS (2),
    .FAKE_TICKS (2),
    .SPEED_TICKS(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [2:0] led;
    logic       ip;
    logic       ro;
    int         ticks;
  } ev_t;

  ev_t        exp_q[$];
  int         checks   = 0;
  int         failures = 0;
  int         ticks_seen = 0;
  logic [4:0] prev = 'x;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    bus.tick = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      bus.tick = 1'b1;
      @(negedge clk);
      bus.tick = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [2:0] led, input logic ip, input logic ro, input int ticks);
    ev_t e;
    e.led = led; e.ip = ip; e.ro = ro; e.ticks = ticks;
    exp_q.push_back(e);
  endtask

  always @(posedge clk) if (bus.tick && !rst) ticks_seen++;

  // Every change of {led_control, in_play, round_over} must match the next queued event.
  always @(negedge clk) begin
    logic [4:0] cur;
    ev_t e;
    cur = {bus.led_control, bus.in_play, bus.round_over};
    check("legal_code", 32'(bus.led_control == 3'b101 || bus.led_control == 3'b111), 32'd0);
    if (cur !== prev) begin
      if (exp_q.size() == 0) begin
        check("unexpected_event", 32'(cur), 32'(prev));
      end else begin
        e = exp_q.pop_front();
        check("led_control", 32'(bus.led_control), 32'(e.led));
        check("in_play", 32'(bus.in_play), 32'(e.ip));
        check("round_over", 32'(bus.round_over), 32'(e.ro));
        if (e.ticks >= 0) check("phase_ticks", 32'(ticks_seen), 32'(e.ticks));
      end
      ticks_seen = 0;
      prev = cur;
    end
  end

  task automatic wait_q(input int n, input string tag);
    int k = 0;
    while (exp_q.size() > n && k < 200) begin
      @(negedge clk);
      #1;
      k++;
    end
    check(tag, 32'(exp_q.size()), 32'(n));
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    bus.start = 1'b0; bus.fake_sel = 1'b0; bus.round_done = 1'b0; bus.speed_req = 1'b0;
    push(3'b001, 1'b0, 1'b0, -1);
    #1 rst = 1'b1;
    repeat (3) step();
    check("reset_led", 32'(bus.led_control), 32'd1);
    check("reset_in_play", 32'(bus.in_play), 32'd0);
    check("reset_round_over", 32'(bus.round_over), 32'd0);

    push(3'b000, 1'b0, 1'b0, 3);
    rst = 1'b0;
    wait_q(0, "show_reset_done");
    repeat (20) step();

    // Real round
    push(3'b010, 1'b0, 1'b0, -1);
    push(3'b011, 1'b1, 1'b0, 2);
    push(3'b000, 1'b0, 1'b1, -1);
    push(3'b000, 1'b0, 1'b0, -1);
    bus.start = 1'b1; step(); bus.start = 1'b0;
    wait_q(2, "enter_play");
    repeat (40) step();
    check("play_no_timeout", 32'(bus.led_control), 32'd3);
    bus.round_done = 1'b1; step(); bus.round_done = 1'b0;
    wait_q(0, "real_round_done");

    // Fake round, round_done ignored
    push(3'b010, 1'b0, 1'b0, -1);
    push(3'b100, 1'b0, 1'b0, 2);
    push(3'b000, 1'b0, 1'b1, 2);
    push(3'b000, 1'b0, 1'b0, -1);
    bus.fake_sel = 1'b1;
    bus.start = 1'b1; step(); bus.start = 1'b0;
    wait_q(2, "enter_fake");
    bus.round_done = 1'b1;
    wait_q(0, "fake_round_done");
    bus.round_done = 1'b0; bus.fake_sel = 1'b0;

    // start beats speed_req
    push(3'b010, 1'b0, 1'b0, -1);
    push(3'b011, 1'b1, 1'b0, 2);
    push(3'b000, 1'b0, 1'b1, -1);
    push(3'b000, 1'b0, 1'b0, -1);
    bus.start = 1'b1; bus.speed_req = 1'b1; step(); bus.start = 1'b0; bus.speed_req = 1'b0;
    wait_q(2, "priority_play");
    bus.round_done = 1'b1; step(); bus.round_done = 1'b0;
    wait_q(0, "priority_done");

    // Speed display, start ignored while in it
    push(3'b110, 1'b0, 1'b0, -1);
    push(3'b000, 1'b0, 1'b0, 4);
    bus.speed_req = 1'b1; step(); bus.speed_req = 1'b0;
    wait_q(1, "enter_speed");
    step();
    bus.start = 1'b1; step(); bus.start = 1'b0;
    wait_q(0, "speed_done");
    repeat (20) step();

    // Held start retriggers WAIT one cycle after leaving FAKE
    push(3'b010, 1'b0, 1'b0, -1);
    push(3'b100, 1'b0, 1'b0, 2);
    push(3'b000, 1'b0, 1'b1, 2);
    push(3'b010, 1'b0, 1'b0, 0);
    push(3'b011, 1'b1, 1'b0, 2);
    bus.fake_sel = 1'b1; bus.start = 1'b1;
    wait_q(1, "retrigger_wait");
    bus.start = 1'b0; bus.fake_sel = 1'b0;
    wait_q(0, "retrigger_play");

    // Asynchronous reset mid-PLAY
    repeat (5) step();
    push(3'b001, 1'b0, 1'b0, -1);
    #1 rst = 1'b1;
    #1;
    check("async_led", 32'(bus.led_control), 32'd1);
    check("async_in_play", 32'(bus.in_play), 32'd0);
    check("async_round_over", 32'(bus.round_over), 32'd0);
    repeat (3) step();
    push(3'b000, 1'b0, 1'b0, 3);
    rst = 1'b0;
    wait_q(0, "post_reset_dark");

    // Illegal state codes recover to DARK
    step();
    force dut.state = 3'b101;
    #1 release dut.state;
    step();
    check("illegal_101", 32'(bus.led_control), 32'd0);
    force dut.state = 3'b111;
    #1 release dut.state;
    step();
    check("illegal_111", 32'(bus.led_control), 32'd0);
    repeat (10) step();

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/led_sequencer.md
LED_SEQUENCER -- requirements
Module: led_sequencer

Interface
REQ-001 Parameter RESET_TICKS, default 2000, ticks the reset code is displayed after reset; legal range 1..4095.
REQ-002 Parameter WAIT_TICKS, default 1000, ticks of the all-on wait phase; legal range 1..4095.
REQ-003 Parameter FAKE_TICKS, default 500, ticks of the fake-round display; legal range 1..4095.
REQ-004 Parameter SPEED_TICKS, default 1500, ticks of the speed display; legal range 1..4095.
REQ-005 clk  input  1  system clock; all state changes on its rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 tick  input  1  one-cycle timebase enable (nominally 1 ms); the only event that advances the phase counter.
REQ-008 start  input  1  level request to begin a round; acted on only in DARK.
REQ-009 fake_sel  input  1  round-type select; sampled only on the cycle WAIT expires.
REQ-010 round_done  input  1  scorer reports the real round is finished; acted on only in PLAY.
REQ-011 speed_req  input  1  request to show the speed pattern; acted on only in DARK.
REQ-012 led_control  output  3  display-select code for the LED multiplexer.
REQ-013 in_play  output  1  high while in PLAY.
REQ-014 round_over  output  1  one-cycle pulse on leaving PLAY or FAKE.

Function
REQ-015 The FSM SHALL have exactly six states, and led_control SHALL equal each state's code, driven directly from the state register: SHOW_RESET=001, DARK=000, WAIT=010, PLAY=011, FAKE=100, SPEED=110.
REQ-016 Codes 101 and 111 SHALL never be driven; an illegal state register value SHALL return to DARK on the next clock.
REQ-017 A 12-bit phase counter SHALL increment on each tick in SHOW_RESET, WAIT, FAKE and SPEED, and SHALL clear on every state transition.
REQ-018 A timed state expires on the clock edge where tick=1 and counter=N-1, N being that state's parameter; a state therefore lasts exactly N ticks.
REQ-019 SHOW_RESET: on expiry -> DARK.
REQ-020 DARK: start=1 -> WAIT; else speed_req=1 -> SPEED; start SHALL win when both are high.
REQ-021 WAIT: on expiry -> FAKE if fake_sel=1 on that cycle, else -> PLAY.
REQ-022 PLAY: round_done=1 -> DARK; tick SHALL be ignored and PLAY SHALL have no timeout.
REQ-023 FAKE: on expiry -> DARK; round_done SHALL be ignored.
REQ-024 SPEED: on expiry -> DARK; start and speed_req SHALL be ignored.
REQ-025 start, speed_req and round_done SHALL be ignored outside their stated states; there is no queuing.
REQ-026 round_over SHALL be registered, high for exactly the one cycle after the edge leaving PLAY or FAKE, and low otherwise.
REQ-027 in_play SHALL be 1 exactly while the state is PLAY.
REQ-028 A held start SHALL retrigger WAIT on the cycle after DARK is re-entered.

Reset
REQ-029 rst=1 SHALL immediately force: state SHOW_RESET, led_control=001, counter=0, in_play=0, round_over=0.
REQ-030 Reset asserted mid-phase, including PLAY, SHALL abort without any round_over pulse.
REQ-031 After rst deasserts, the first tick SHALL count as tick 1 of SHOW_RESET.

Verification (bench parameters RESET_TICKS=3, WAIT_TICKS=2, FAKE_TICKS=2, SPEED_TICKS=4; tick every 4 clks)
REQ-032 Release reset, no inputs -> led_control 001 for exactly 3 ticks, then 000, and it stays 000.
REQ-033 In DARK: start pulse, fake_sel=0 -> 010 for 2 ticks, then 011 with in_play=1; round_done -> 000 with a one-cycle round_over.
REQ-034 Same sequence with fake_sel=1 at WAIT expiry -> 100 for 2 ticks regardless of round_done, then 000 with round_over; in_play stays 0.
REQ-035 In DARK: start and speed_req high on the same cycle -> WAIT; speed_req alone -> 110 for 4 ticks, then 000; a start during SPEED is ignored.
REQ-036 rst asserted mid-PLAY between clock edges -> led_control 001 without waiting for an edge, and no round_over pulse.
REQ-037 Force an illegal state code -> DARK on the next clock; led_control never shows 101 or 111.
